uart_rx_word_receiver: RTL and testbench
========================================

// Module: uart_rx_word_receiver
// PURPOSE
//  Serial receiver downstream of the 32-bit UART transmitter; consumes its TransmittedSerialData line.
//  Frame: start(0), 32 data bits LSB first, optional parity bit, one stop(1).
//  Oversamples the line, checks start/parity/stop and presents the 32-bit word on a valid/ack handshake.
//  Reports parity, framing and overrun errors.
// PARAMETERS
//  OVS        16  CLK_Baudin cycles per bit; even, >=4
//  DATA_W     32  data bits per frame
//  PARITY_EN  1   1: parity bit present after data; 0: stop follows data directly
//  PARITY_ODD 0   0: even parity (data^parity XOR == 0); 1: odd
// PORTS
//  CLK_Baudin   in   1       receive clock, OVS x bit rate; single clock domain
//  RstRx        in   1       asynchronous reset, active-low
//  SerialIn     in   1       asynchronous serial line, idle high
//  DataOut      out  DATA_W  last received word; stable while DataValid=1
//  DataValid    out  1       word available; held until DataAck
//  DataAck      in   1       consumer accepts word; clears DataValid next cycle
//  DoneRx       out  1       one-cycle pulse per completed frame (good or bad)
//  ParityErr    out  1       sticky-per-frame: parity mismatch on last frame
//  FrameErr     out  1       sticky-per-frame: stop bit sampled 0 on last frame
//  OverrunErr   out  1       frame completed while DataValid still 1; cleared by DataAck
//  Busy         out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset (RstRx=0, async): state IDLE; all outputs 0; DataOut=0; counters 0; sync flops = 1.
//  Input: SerialIn through 2-flop synchronizer (reset to 1); all decisions use synced value rx_s.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//   IDLE: rx_s 1->0 edge -> START, tick counter cleared.
//   START: at tick OVS/2-1 sample rx_s; 0 -> DATA (tick=0, bit=0); 1 -> IDLE (glitch, no flags).
//   DATA: sample every OVS ticks (mid-bit); shift right into data reg, MSB-in;
//     after bit DATA_W-1 -> PARITY if PARITY_EN else STOP.
//   PARITY: mid-bit sample; perr = (^data ^ p) != PARITY_ODD; -> STOP.
//   STOP: mid-bit sample; 1 -> IDLE; 0 -> WAIT_IDLE with FrameErr.
//   WAIT_IDLE: stay until rx_s=1 (break / stuck-low line); then IDLE. No new start detected here.
//  Completion (cycle after stop sample): DoneRx=1 for one cycle; ParityErr/FrameErr updated for this frame.
//   If DataValid=0: DataOut<=data, DataValid<=1.
//   If DataValid=1 (unacked): DataOut unchanged, OverrunErr<=1, new word dropped.
//   Word with parity or framing error is still delivered; error flags qualify it.
//  DataAck: when DataValid=1, clears DataValid and OverrunErr next cycle; ignored when DataValid=0.
//  Simultaneous DataAck and completion: ack consumes the old word, new word loaded, DataValid stays 1, no overrun.
//  Latency: line start edge to DoneRx = 2 (sync) + (1+DATA_W+PARITY_EN)*OVS + OVS/2 + 1 cycles, nominal.
//  Tick counter wraps at OVS-1; bit counter width clog2(DATA_W+1); no other wrap cases.
//  Reset mid-frame: frame discarded, returns to IDLE; a partial frame after reset release is
//   not recognised until the next idle-to-low edge.
// STRUCTURE
//  Shared include uart_defs.vh: FSM state encodings, frame constants (START_BIT=0, STOP_BIT=1),
//   DATA_W default, parity-mode defines; shared with the transmitter.
//  Sub-module: uart_rx_sync (2-flop synchronizer + falling-edge detect, async active-low reset, reset value 1).
//  Main module: FSM, tick/bit counters, shift register, output register and handshake.
// TESTING
//  Drive 32'hA5C3_0F1E, even parity, OVS=16 -> one DoneRx, DataOut=32'hA5C3_0F1E, DataValid=1, no error flags.
//  Same word with flipped parity bit -> DataOut=32'hA5C3_0F1E, ParityErr=1, FrameErr=0.
//  Stop bit forced 0, then line low 40 bit-times -> FrameErr=1, Busy=1 until line high, then IDLE.
//  Two back-to-back frames 32'h1, 32'h2 with no DataAck -> DataOut=32'h1, OverrunErr=1; DataAck clears both.
//  Low glitch of OVS/4 cycles on idle line -> returns to IDLE, no DoneRx, no flags.
//  RstRx asserted mid-DATA (bit 12) -> all outputs 0 immediately; next full frame 32'hDEAD_BEEF received correctly.

Source files
------------

// File: rtl/uart_rx_word_receiver_pkg.sv
// Shared definitions for the UART word receiver: FSM state encoding, frame-level constants,
// default frame geometry and the parity check helper.
package uart_rx_word_receiver_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_e;

    // Line levels of the framing bits; the idle line sits at STOP_BIT.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned DefaultOvs   = 16;
    localparam int unsigned DefaultDataW = 32;

    // True when the received parity bit disagrees with the selected parity mode.
    // data_xor is the XOR reduction of the data bits; odd selects odd parity.
    function automatic logic parity_mismatch(logic data_xor, logic par_bit, logic odd);
        return (data_xor ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
// All flops reset to the idle line level so reset never looks like a start edge.
// Ports:
//   clk_i   receive clock
//   rst_ni  asynchronous active-low reset
//   rx_i    raw serial line
//   rx_s_o  synchronized line value
//   fall_o  one-cycle pulse when the synchronized line goes 1 -> 0
module uart_rx_sync
    import uart_rx_word_receiver_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic rx_s_q, rx_s_d;
    logic rx_prev_q, rx_prev_d;

    always_comb begin
        meta_d    = rx_i;
        rx_s_d    = meta_q;
        rx_prev_d = rx_s_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q    <= STOP_BIT;
            rx_s_q    <= STOP_BIT;
            rx_prev_q <= STOP_BIT;
        end else begin
            meta_q    <= meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    assign rx_s_o = rx_s_q;
    assign fall_o = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_word_receiver.sv
// Oversampling UART receiver for DATA_W-bit words: start, data LSB first, optional parity,
// one stop bit. The received word is offered on a valid/ack handshake with parity, framing
// and overrun qualifiers.
// Ports:
//   CLK_Baudin  receive clock, OVS x bit rate
//   RstRx       asynchronous active-low reset
//   SerialIn    asynchronous serial line, idle high
//   DataOut     last delivered word, stable while DataValid
//   DataValid   word available, held until DataAck
//   DataAck     consumer accepts the word
//   DoneRx      one-cycle pulse per completed frame
//   ParityErr   parity mismatch on the last frame
//   FrameErr    stop bit sampled low on the last frame
//   OverrunErr  frame completed while the previous word was unacknowledged
//   Busy        receiver not idle
module uart_rx_word_receiver
    import uart_rx_word_receiver_pkg::*;
#(
    parameter int unsigned OVS        = DefaultOvs,
    parameter int unsigned DATA_W     = DefaultDataW,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              CLK_Baudin,
    input  logic              RstRx,
    input  logic              SerialIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    input  logic              DataAck,
    output logic              DoneRx,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              OverrunErr,
    output logic              Busy
);

    localparam int unsigned TickW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int unsigned BitW  = $clog2(DATA_W + 1);

    localparam logic [TickW-1:0] TickHalf = TickW'(OVS / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVS - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk_i  (CLK_Baudin),
        .rst_ni (RstRx),
        .rx_i   (SerialIn),
        .rx_s_o (rx_s),
        .fall_o (rx_fall)
    );

    rx_state_e         state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              ovr_q, ovr_d;

    logic complete;
    logic ack_take;

    // Frame sequencing: tick counter marks mid-bit sample points, bit counter tracks data bits.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        complete = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_fall) begin
                    state_d = StStart;
                    tick_d  = '0;
                end
            end
            StStart: begin
                // Re-check the start bit half a bit in; a high line here was a glitch.
                if (tick_q == TickHalf) begin
                    tick_d = '0;
                    if (rx_s == START_BIT) begin
                        state_d = StData;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StData: begin
                if (tick_q == TickLast) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    if (bit_q == BitLast) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                        perr_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StParity: begin
                if (tick_q == TickLast) begin
                    tick_d  = '0;
                    perr_d  = parity_mismatch(^shift_q, rx_s, PARITY_ODD != 0);
                    state_d = StStop;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StStop: begin
                if (tick_q == TickLast) begin
                    tick_d   = '0;
                    complete = 1'b1;
                    state_d  = (rx_s == STOP_BIT) ? StIdle : StWaitIdle;
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StWaitIdle: begin
                // Line held low past the stop bit: wait for it to recover before rearming.
                if (rx_s == STOP_BIT) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output register and handshake. An ack in the completion cycle frees the slot for the
    // new word, so it is loaded instead of flagged as an overrun.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        ovr_d     = ovr_q;
        ack_take  = DataAck & valid_q;

        if (ack_take) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        if (complete) begin
            done_d    = 1'b1;
            par_err_d = perr_q;
            frm_err_d = (rx_s != STOP_BIT);
            if (!valid_q || ack_take) begin
                dout_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_Baudin or negedge RstRx) begin
        if (!RstRx) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign DataOut    = dout_q;
    assign DataValid  = valid_q;
    assign DoneRx     = done_q;
    assign ParityErr  = par_err_q;
    assign FrameErr   = frm_err_q;
    assign OverrunErr = ovr_q;
    assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_word_receiver.sv
// Scoreboard bench for uart_rx_word_receiver: frames are built from their bit definition,
// expected per-frame results are queued at send time, and a negedge monitor checks each
// DoneRx against the queue and a high-level model of the one-word output slot.
module tb_uart_rx_word_receiver;

    localparam int OVS    = 16;
    localparam int DATA_W = 32;
    // Line start edge to DoneRx, nominal.
    localparam int DoneLat = 2 + (1 + DATA_W + 1) * OVS + OVS / 2 + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              serial_in;
    logic              data_ack;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              done_rx;
    logic              parity_err;
    logic              frame_err;
    logic              overrun_err;
    logic              busy;

    always #5 clk = ~clk;

    uart_rx_word_receiver #(
        .OVS        (OVS),
        .DATA_W     (DATA_W),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .CLK_Baudin (clk),
        .RstRx      (rst_n),
        .SerialIn   (serial_in),
        .DataOut    (data_out),
        .DataValid  (data_valid),
        .DataAck    (data_ack),
        .DoneRx     (done_rx),
        .ParityErr  (parity_err),
        .FrameErr   (frame_err),
        .OverrunErr (overrun_err),
        .Busy       (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        perr;
        logic        ferr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; ack_sim raises DataAck for exactly the completion edge,
    // cut >= 0 abandons the frame after that many bit-clock cycles.
    task automatic send_frame(input logic [31:0] word, input bit flip_par, input bit stop_val,
                              input bit ack_sim, input int cut);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(word[i]);
        bits.push_back((^word) ^ flip_par);
        bits.push_back(stop_val);
        e.data = word;
        e.perr = flip_par;
        e.ferr = !stop_val;
        sb_q.push_back(e);
        for (int c = 0; c < bits.size() * OVS; c++) begin
            if (cut >= 0 && c == cut) return;
            @(posedge clk);
            #1;
            serial_in = bits[c / OVS];
            if (ack_sim) data_ack = (c == DoneLat - 1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && sb_q.size() != 0; i++) wait_cycles(1);
        check("frames_outstanding", sb_q.size(), 0);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        wait_cycles(1);
        data_ack = 1'b0;
        wait_cycles(2);
    endtask

    // Monitor: model of the single output slot, updated from observed acks and completions.
    logic        m_valid;
    logic        m_ovr;
    logic        m_ack_pend;
    logic        m_acked;
    logic [31:0] m_dout;
    exp_t        m_e;

    initial begin
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_ack_pend = 1'b0;
        m_dout = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_valid = 1'b0;
                m_ovr = 1'b0;
                m_ack_pend = 1'b0;
                m_dout = '0;
            end else begin
                m_acked = m_ack_pend;
                if (m_acked) begin
                    m_valid = 1'b0;
                    m_ovr = 1'b0;
                end
                if (done_rx) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done_rx", done_rx, 0);
                    end else begin
                        m_e = sb_q.pop_front();
                        if (!m_valid) begin
                            m_dout = m_e.data;
                            m_valid = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                        check("parity_err", parity_err, m_e.perr);
                        check("frame_err", frame_err, m_e.ferr);
                        check("data_valid", data_valid, m_valid);
                        check("data_out", data_out, m_dout);
                        check("overrun_err", overrun_err, m_ovr);
                    end
                end else if (m_acked) begin
                    check("ack_data_valid", data_valid, m_valid);
                    check("ack_overrun_err", overrun_err, m_ovr);
                end
                m_ack_pend = data_ack && m_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    logic [31:0] w1, w2;

    initial begin
        rst_n = 1'b1;
        serial_in = 1'b1;
        data_ack = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_done_rx", done_rx, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun_err", overrun_err, 0);
        check("rst_busy", busy, 0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);

        // Clean frame.
        send_frame(32'hA5C3_0F1E, 1'b0, 1'b1, 1'b0, -1);
        drain();
        check("good_word", data_out, 32'hA5C3_0F1E);
        ack_pulse();

        // Flipped parity bit.
        send_frame(32'hA5C3_0F1E, 1'b1, 1'b1, 1'b0, -1);
        drain();
        check("perr_flag", parity_err, 1);
        ack_pulse();

        // Stop bit low, line stuck low for 40 bit-times.
        send_frame(32'h1234_5678, 1'b0, 1'b0, 1'b0, -1);
        drain();
        wait_cycles(40 * OVS - 16);
        check("break_busy", busy, 1);
        check("break_frame_err", frame_err, 1);
        serial_in = 1'b1;
        wait_cycles(5);
        check("break_recover_busy", busy, 0);
        ack_pulse();

        // Back-to-back frames, no ack between them.
        send_frame(32'h0000_0001, 1'b0, 1'b1, 1'b0, -1);
        send_frame(32'h0000_0002, 1'b0, 1'b1, 1'b0, -1);
        drain();
        check("b2b_data_out", data_out, 32'h1);
        check("b2b_overrun", overrun_err, 1);
        ack_pulse();
        check("b2b_ack_valid", data_valid, 0);
        check("b2b_ack_overrun", overrun_err, 0);

        // Short low glitch on the idle line.
        serial_in = 1'b0;
        wait_cycles(OVS / 4);
        serial_in = 1'b1;
        wait_cycles(3 * OVS);
        check("glitch_busy", busy, 0);
        check("glitch_valid", data_valid, 0);
        check("glitch_perr", parity_err, 0);
        check("glitch_ferr", frame_err, 0);

        // Randomized frames with random parity/stop faults, ack choice and idle gaps.
        for (int k = 0; k < 8; k++) begin
            bit flip, stop;
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 3) != 0);
            send_frame($urandom, flip, stop, 1'b0, -1);
            serial_in = 1'b1;
            drain();
            if ($urandom_range(0, 2) != 0) ack_pulse();
            wait_cycles($urandom_range(2, 20));
        end

        // Ack landing on the same edge as the next completion.
        w1 = $urandom;
        w2 = $urandom;
        send_frame(w1, 1'b0, 1'b1, 1'b0, -1);
        drain();
        send_frame(w2, 1'b0, 1'b1, 1'b1, -1);
        drain();
        wait_cycles(1);
        check("sim_ack_data_out", data_out, w2);
        check("sim_ack_valid", data_valid, 1);
        check("sim_ack_overrun", overrun_err, 0);

        // Reset in the middle of data bit 12, word left unacknowledged.
        send_frame(32'h5555_AAAA, 1'b0, 1'b1, 1'b0, (1 + 12) * OVS + OVS / 2);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_data_out", data_out, 0);
        check("midrst_valid", data_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun_err, 0);
        check("midrst_perr", parity_err, 0);
        check("midrst_ferr", frame_err, 0);
        serial_in = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(8);
        send_frame(32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, -1);
        drain();
        check("post_rst_word", data_out, 32'hDEAD_BEEF);
        check("post_rst_valid", data_valid, 1);
        ack_pulse();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
